// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, then one sign/special-case fix-up cycle.
// Optional macro DIV_EARLY_OUT_EN: resolves divide-by-zero, signed overflow and
// |rs1| < |rs2| straight from IDLE with a single busy cycle.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid_i,
  input  logic [1:0]      funct3_lo_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntMax = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q;
  logic [XLEN-1:0] quo_q, rem_q, div_q, rs1_q, result_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      op_q;
  logic            q_neg_q, r_neg_q, div0_q, ovf_q, busy_q, done_q;

  logic            is_signed, start_div0, start_ovf, early;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] quo_fix, rem_fix, res_fix;

  // Start-cycle operand conditioning and early-out decision.
  always_comb begin
    is_signed  = ~funct3_lo_i[0];
    abs_a      = (is_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    abs_b      = (is_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
    start_div0 = (rs2_i == '0);
    start_ovf  = is_signed && (rs1_i == MinInt) && (rs2_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early      = start_div0 | start_ovf | (abs_a < abs_b);
`else
    early      = 1'b0;
`endif
  end

  // One restoring step: shift {rem, quo} left, subtract divisor if it fits.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, div_q});
    // Only used when rem_ge, so the difference always fits in XLEN bits.
    rem_sub = rem_sh[XLEN-1:0] - div_q;
  end

  // Sign correction, RISC-V special cases and result selection.
  always_comb begin
    quo_fix = (~op_q[0] & q_neg_q) ? -quo_q : quo_q;
    rem_fix = (~op_q[0] & r_neg_q) ? -rem_q : rem_q;
    if (div0_q) begin
      quo_fix = '1;
      rem_fix = rs1_q;
    end else if (ovf_q) begin
      quo_fix = MinInt;
      rem_fix = '0;
    end
    res_fix = op_q[1] ? rem_fix : quo_fix;
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      rs1_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (op_valid_i) begin
            op_q    <= funct3_lo_i;
            rs1_q   <= rs1_i;
            div_q   <= abs_b;
            q_neg_q <= is_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            r_neg_q <= is_signed & rs1_i[XLEN-1];
            div0_q  <= start_div0;
            ovf_q   <= start_ovf;
            cnt_q   <= CntMax;
            busy_q  <= 1'b1;
            if (early) begin
              // Quotient 0 / remainder |rs1|; the fix-up restores rs1's sign.
              quo_q   <= '0;
              rem_q   <= abs_a;
              state_q <= StFix;
            end else begin
              quo_q   <= abs_a;
              rem_q   <= '0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          quo_q <= {quo_q[XLEN-2:0], rem_ge};
          rem_q <= rem_ge ? rem_sub : rem_sh[XLEN-1:0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          result_q <= res_fix;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
